// File: rtl/seg_scan_driver_pkg.sv
// Purpose : shared constants and types for the seven-segment scan driver.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: blank/off codes, FSM state encoding, digit index width.
package seg_scan_driver_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;  // all cathodes off (active-low)
    localparam logic [3:0] AN_OFF    = 4'hF;   // all anodes off (active-low)
    localparam int         IDX_W     = 2;      // four digits

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Anode word for one lit slot: only the selected anode may go low,
    // and only when that digit is enabled.
    function automatic logic [3:0] an_for_slot(input logic [IDX_W-1:0] idx,
                                               input logic [3:0]       en);
        logic [3:0] a;
        a      = AN_OFF;
        a[idx] = ~en[idx];
        return a;
    endfunction

endpackage

// File: rtl/seg_scan_driver_timer.sv
// Purpose : phase counter for the scan FSM; flags the last cycle of a phase.
// Latency : done is combinational from the registered count.
// Backpressure : none; runs every cycle.
// Ports: clk, rst_n (sync, active-low), restart (clear count), sel (1=dwell
//        length, 0=blank length), done (last cycle of the selected phase).
module scan_timer #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic sel,
    output logic done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // A zero-length blank phase can still occur once after reset; treat it
    // as a single cycle so the FSM leaves it immediately.
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == (sel ? DWELL_LAST : BLANK_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose : time-multiplex four active-low 7-seg patterns onto one seg bus.
// Latency : outputs registered, change on the same edge as the state/idx.
// Backpressure : none; load is a one-cycle request, acked at the frame edge.
// Ports: clk, rst_n (sync, active-low), seg_in[27:0] (digit0 in [6:0]),
//        dig_en[3:0], load -> load_ack, frame_start, seg[6:0], an[3:0].
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    state_t            state, nxt_state;
    logic [IDX_W-1:0]  idx, nxt_idx;
    logic [27:0]       active, staging, nxt_active;
    logic              pending;
    logic              done, boundary, commit;
    logic [6:0]        nxt_seg;
    logic [3:0]        nxt_an;

    scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (done),
        .sel     (state == ST_SHOW),
        .done    (done)
    );

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        if (done) begin
            if (state == ST_SHOW) begin
                nxt_idx   = idx + 2'd1;
                nxt_state = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            end else begin
                nxt_state = ST_SHOW;
            end
        end

        // Frame boundary: the edge that finishes digit 3's dwell.
        boundary = done && (state == ST_SHOW) && (idx == 2'd3);
        commit   = boundary && (pending || load);

        // A load in the boundary cycle itself bypasses staging so it still
        // lands in the frame that is starting.
        nxt_active = active;
        if (commit) begin
            nxt_active = load ? seg_in : staging;
        end

        // Outputs are computed from next-state values so they move on the
        // same edge as the FSM, with no extra pipeline stage.
        nxt_an  = AN_OFF;
        nxt_seg = SEG_BLANK;
        if (nxt_state == ST_SHOW) begin
            nxt_an  = an_for_slot(nxt_idx, dig_en);
            nxt_seg = nxt_active[nxt_idx*7 +: 7];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            idx         <= '0;
            active      <= {4{SEG_BLANK}};
            staging     <= {4{SEG_BLANK}};
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            active      <= nxt_active;
            if (load) begin
                staging <= seg_in;
            end
            pending     <= commit ? 1'b0 : (pending | load);
            load_ack    <= commit;
            frame_start <= boundary;
            seg         <= nxt_seg;
            an          <= nxt_an;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose : directed self-checking bench for seg_scan_driver (DWELL=4, BLANK=2).
// Latency : k counts clock edges since reset release; a frame is 24 edges.
// Backpressure : n/a.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] seg_in = '0;
    logic [3:0]  dig_en = 4'hF;
    logic        load = 1'b0;
    logic        load_ack, frame_start;
    logic [6:0]  seg;
    logic [3:0]  an;

    int          k;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [27:0] m_act;
    logic [3:0]  m_en;
    logic [11:0] exp_v;

    seg_scan_driver #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2),
        .CNT_W        (17)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    // Expected {an, seg, frame_start} after edge kk. Phase p within the
    // 24-edge frame: slot d = p/6, blank when p%6 < 2.
    function automatic logic [11:0] model(input int kk, input logic [27:0] act,
                                          input logic [3:0] en);
        int p, d, w;
        logic [3:0] a;
        logic [6:0] s;
        p = kk % 24;
        d = p / 6;
        w = p % 6;
        a = 4'hF;
        s = 7'h7F;
        if (w >= 2) begin
            a[d] = ~en[d];
            s    = act[d*7 +: 7];
        end
        return {a, s, (p == 0) && (kk > 0)};
    endfunction

    function automatic logic [27:0] rep4(input logic [6:0] x);
        return {x, x, x, x};
    endfunction

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        load   = 1'b0;
        dig_en = 4'hF;
        seg_in = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if ({an, seg, load_ack, frame_start} !== {4'hF, 7'h7F, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_hold: an=%h seg=%h ack=%b fs=%b, want an=f seg=7f ack=0 fs=0",
                         an, seg, load_ack, frame_start);
            end
        end
        rst_n = 1'b1;
        k     = 0;
        m_act = rep4(7'h7F);
        m_en  = 4'hF;
        for (int i = 0; i < 24; i++) begin
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_frame k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=0",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
            if (k == 2 || k == 8) begin
                n_tests++;
                if (an !== ((k == 2) ? 4'b1110 : 4'b1101)) begin
                    n_fail++;
                    $display("FAIL reset_first_slots k=%0d: an=%b", k, an);
                end
            end
        end
    endtask

    task automatic test_load_mid_frame();
        int          hk [4] = '{50, 56, 62, 68};
        logic [10:0] hv [4] = '{{4'b1110, 7'h40}, {4'b1101, 7'h79},
                                {4'b1011, 7'h24}, {4'b0111, 7'h30}};
        for (int i = 0; i < 24; i++) begin
            if (k == 28) begin
                load   = 1'b1;
                seg_in = {7'h30, 7'h24, 7'h79, 7'h40};
            end else begin
                load = 1'b0;
            end
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== (k == 48)) begin
                n_fail++;
                $display("FAIL load_mid k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=%b",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0], k == 48);
            end
        end
        m_act = {7'h30, 7'h24, 7'h79, 7'h40};
        for (int i = 0; i < 24; i++) begin
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL load_mid_show k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=0",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
            for (int j = 0; j < 4; j++) begin
                if (k == hk[j]) begin
                    n_tests++;
                    if ({an, seg} !== hv[j]) begin
                        n_fail++;
                        $display("FAIL load_mid_digit%0d: an=%b seg=%h, want an=%b seg=%h",
                                 j, an, seg, hv[j][10:7], hv[j][6:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_double_load();
        for (int i = 0; i < 24; i++) begin
            load = (k == 74) || (k == 79);
            if (k == 74) seg_in = rep4(7'h79);
            if (k == 79) seg_in = rep4(7'h24);
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== (k == 96)) begin
                n_fail++;
                $display("FAIL double_load k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=%b",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0], k == 96);
            end
        end
        load  = 1'b0;
        m_act = rep4(7'h24);
    endtask

    task automatic test_back_to_back();
        // Frame shows the double-load result; a load lands exactly on the
        // next boundary and must be visible in the frame right after it.
        for (int i = 0; i < 48; i++) begin
            load = (k == 119);
            if (k == 119) seg_in = rep4(7'h40);
            step();
            if (k == 121) m_act = rep4(7'h40);
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== (k == 120)) begin
                n_fail++;
                $display("FAIL boundary_load k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=%b",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0], k == 120);
            end
            if (k == 122) begin
                n_tests++;
                if (seg !== 7'h40) begin
                    n_fail++;
                    $display("FAIL boundary_load_visible: seg=%h, want 40", seg);
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_dig_en();
        dig_en = 4'b0101;
        m_en   = 4'b0101;
        for (int i = 0; i < 24; i++) begin
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL dig_en k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=0",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
            if (k == 152 || k == 167) begin
                n_tests++;
                if (an !== 4'hF) begin
                    n_fail++;
                    $display("FAIL dig_en_off k=%0d: an=%b, want 1111", k, an);
                end
            end
        end
        dig_en = 4'hF;
        m_en   = 4'hF;
    endtask

    task automatic test_reset_mid();
        while (k < 183) begin
            load = (k == 168);
            if (k == 168) seg_in = rep4(7'h06);
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=0",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
        load  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({an, seg, load_ack, frame_start} !== {4'hF, 7'h7F, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid_now: an=%b seg=%h ack=%b fs=%b, want an=1111 seg=7f ack=0 fs=0",
                     an, seg, load_ack, frame_start);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        m_act = rep4(7'h7F);
        for (int i = 0; i < 48; i++) begin
            step();
            exp_v = model(k, m_act, m_en);
            n_tests++;
            if ({an, seg, frame_start} !== exp_v || load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after k=%0d: an=%b seg=%h fs=%b ack=%b, want an=%b seg=%h fs=%b ack=0",
                         k, an, seg, frame_start, load_ack, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        k = 0;
        test_reset();
        test_load_mid_frame();
        test_double_load();
        test_back_to_back();
        test_dig_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
